// File: rtl/ql_cfg_pkg.sv
// ----------------------------------------------------------------------------
// ql_cfg_pkg
// Shared definitions for the QL memory-bank configuration loader:
//   - cfg_state_e   : loader FSM states
//   - default widths: bit lines / word lines per config region, stream width,
//                     word-line pulse length
//   - words_per_row : stream words needed to fill one row of bit lines
// ----------------------------------------------------------------------------
package ql_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    SETTLE,
    DONE
  } cfg_state_e;

  localparam int unsigned DEFAULT_BL_WIDTH = 514;
  localparam int unsigned DEFAULT_WL_WIDTH = 407;
  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_WL_PULSE = 2;

  // Ceiling division: the last word of a row may be only partly used.
  function automatic int unsigned words_per_row(input int unsigned bl_width,
                                                input int unsigned data_w);
    return (bl_width + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/ql_membank_cfg_loader_if.sv
// ----------------------------------------------------------------------------
// ql_membank_cfg_loader_if
// Valid/ready bitstream word stream feeding the configuration loader.
//   s_valid : source has a word on s_data
//   s_ready : loader accepts the word this cycle
//   s_data  : bitstream word, bit i lands on bit line (word*DATA_W + i)
// Modports: master = bitstream source, slave = loader.
// ----------------------------------------------------------------------------
interface ql_membank_cfg_loader_if #(
  parameter int DATA_W = 32
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/ql_cfg_row_decoder.sv
// ----------------------------------------------------------------------------
// ql_cfg_row_decoder
// Turns the current row index into the word-line strobe.
//   row_idx : row being programmed
//   en      : strobe enable (high only while the row is being pulsed)
//   wl      : one-hot word lines when enabled, all zero otherwise
// ----------------------------------------------------------------------------
module ql_cfg_row_decoder #(
  parameter int WL_WIDTH = 407,
  parameter int ROW_W    = 9
) (
  input  logic [ROW_W-1:0]    row_idx,
  input  logic                en,
  output logic [0:WL_WIDTH-1] wl
);

  always_comb begin
    wl = '0;
    for (int i = 0; i < WL_WIDTH; i++) begin
      if (en && (row_idx == ROW_W'(i))) begin
        wl[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ql_membank_cfg_loader.sv
// ----------------------------------------------------------------------------
// ql_membank_cfg_loader
// Programs a memory-bank config region row by row: collects WPR stream words
// into the bit-line register, strobes the row's word line for WL_PULSE cycles,
// idles one settle cycle with the word lines low, then moves to the next row.
//
// Ports
//   clk           : clock
//   global_resetn : asynchronous active-low reset
//   start         : one-cycle request to load all rows (honoured in IDLE/DONE)
//   stream        : bitstream word stream (slave side)
//   bl            : bit-line data for the current row
//   wl            : word-line strobe, one-hot during a pulse, else zero
//   row_idx       : row currently being loaded / pulsed
//   busy          : high while a load is in progress
//   done          : high once every row has been programmed
// ----------------------------------------------------------------------------
module ql_membank_cfg_loader
  import ql_cfg_pkg::*;
#(
  parameter int   BL_WIDTH = DEFAULT_BL_WIDTH,
  parameter int   WL_WIDTH = DEFAULT_WL_WIDTH,
  parameter int   DATA_W   = DEFAULT_DATA_W,
  parameter int   WL_PULSE = DEFAULT_WL_PULSE,
  localparam int  ROW_W    = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1
) (
  input  logic                clk,
  input  logic                global_resetn,
  input  logic                start,
  ql_membank_cfg_loader_if.slave stream,
  output logic [0:BL_WIDTH-1] bl,
  output logic [0:WL_WIDTH-1] wl,
  output logic [ROW_W-1:0]    row_idx,
  output logic                busy,
  output logic                done
);

  localparam int WPR    = words_per_row(BL_WIDTH, DATA_W);
  localparam int WCNT_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int PCNT_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  cfg_state_e        state;
  cfg_state_e        next_state;
  logic [WCNT_W-1:0] word_cnt;
  logic [PCNT_W-1:0] pulse_cnt;

  logic s_ready;
  logic wl_en;
  logic accept;
  logic last_word;
  logic last_pulse;
  logic last_row;

  assign stream.s_ready = s_ready;
  assign accept         = stream.s_valid & s_ready;
  assign last_word      = (word_cnt == WCNT_W'(WPR - 1));
  assign last_pulse     = (pulse_cnt == PCNT_W'(WL_PULSE - 1));
  assign last_row       = (row_idx == ROW_W'(WL_WIDTH - 1));

  // State register plus the row / word / pulse counters that advance with it.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would let later lines see new ones.
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state     <= IDLE;
      row_idx   <= '0;
      word_cnt  <= '0;
      pulse_cnt <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            row_idx  <= '0;
            word_cnt <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            word_cnt  <= last_word ? '0 : word_cnt + 1'b1;
            pulse_cnt <= '0;
          end
        end
        PULSE: begin
          pulse_cnt <= pulse_cnt + 1'b1;
        end
        SETTLE: begin
          // DONE keeps the last row index; a restart clears it.
          if (!last_row) begin
            row_idx <= row_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: next_state is given a default before the case so no path through
  // this block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: if (start)                 next_state = LOAD;
      LOAD:       if (accept && last_word)   next_state = PULSE;
      PULSE:      if (last_pulse)            next_state = SETTLE;
      SETTLE:     next_state = last_row ? DONE : LOAD;
      default:    next_state = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so s_ready never depends on
  // s_valid in the same cycle.
  always_comb begin
    s_ready = 1'b0;
    wl_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      PULSE: begin
        wl_en = 1'b1;
        busy  = 1'b1;
      end
      SETTLE:  busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Bit-line register file: the accepted word lands in chunk word_cnt.
  // Bits of the last word that fall past BL_WIDTH-1 have no destination.
  // Writes happen only in LOAD, so bl is stable while any word line is high.
  // NOTE: bl is reset because it drives the fabric directly and must be a
  // known zero as soon as reset asserts; a pure data buffer would not need it.
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      bl <= '0;
    end else if (accept) begin
      for (int b = 0; b < BL_WIDTH; b++) begin
        if (word_cnt == WCNT_W'(b / DATA_W)) begin
          bl[b] <= stream.s_data[b % DATA_W];
        end
      end
    end
  end

  ql_cfg_row_decoder #(
    .WL_WIDTH (WL_WIDTH),
    .ROW_W    (ROW_W)
  ) u_row_decoder (
    .row_idx (row_idx),
    .en      (wl_en),
    .wl      (wl)
  );

endmodule
